// File: rtl/rtc_frame_capture.sv
// rtc_frame_capture
// Collects the 9-byte time/date frame streamed by the RTC address sequencer
// into a shadow buffer and copies it to the readable bank in a single cycle.
// Display logic therefore never sees a frame that is only partly updated.
// Optional build macro: RTC_BCD_CHECK_EN. When it is defined, any byte that
// has a nibble above 9 is treated as an out-of-sequence byte.
module rtc_frame_capture #(
  parameter int NUM_REGS = 9,
  parameter int DW       = 8,
  parameter int AW       = 4
) (
  input  logic          clkREG,
  input  logic          resetREG,
  input  logic          enREG,
  input  logic [AW-1:0] addrREG,
  input  logic [DW-1:0] dinREG,
  input  logic          strobeREG,
  input  logic [AW-1:0] rd_addrREG,
  output logic [DW-1:0] rd_dataREG,
  output logic          busyREG,
  output logic          frame_doneREG,
  output logic          seq_errREG,
  output logic [7:0]    frame_cntREG
);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] expect_q, expect_d;
  logic [DW-1:0] shadow_q [NUM_REGS];
  logic [DW-1:0] shadow_d [NUM_REGS];
  logic [DW-1:0] bank_q   [NUM_REGS];
  logic [DW-1:0] bank_d   [NUM_REGS];
  logic          frameDone_q, frameDone_d;
  logic          seqErr_q, seqErr_d;
  logic [7:0]    frameCnt_q, frameCnt_d;
  logic          bcdBad;

  // Flag bytes that are not valid BCD. Without the macro, no byte is ever rejected.
  always_comb begin
`ifdef RTC_BCD_CHECK_EN
    bcdBad = (dinREG[DW-1:DW-4] > 4'd9) || (dinREG[3:0] > 4'd9);
`else
    bcdBad = 1'b0;
`endif
  end

  // State register. A reset clears everything and drops any partial frame.
  always_ff @(posedge clkREG) begin
    if (resetREG) begin
      state_q     <= IDLE;
      expect_q    <= '0;
      frameDone_q <= 1'b0;
      seqErr_q    <= 1'b0;
      frameCnt_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        bank_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      frameDone_q <= frameDone_d;
      seqErr_q    <= seqErr_d;
      frameCnt_q  <= frameCnt_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
        bank_q[i]   <= bank_d[i];
      end
    end
  end

  // Next-state logic: sequence checking, shadow capture, and the one-cycle commit.
  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    frameDone_d = 1'b0;
    seqErr_d    = 1'b0;
    frameCnt_d  = frameCnt_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_d[i] = shadow_q[i];
      bank_d[i]   = bank_q[i];
    end
    case (state_q)
      IDLE: begin
        if (enREG && strobeREG) begin
          if (bcdBad || (addrREG != '0)) begin
            seqErr_d = 1'b1;
          end else begin
            shadow_d[0] = dinREG;
            expect_d    = AW'(1);
            state_d     = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (!enREG) begin
          state_d  = IDLE;
          expect_d = '0;
        end else if (strobeREG) begin
          if (bcdBad) begin
            seqErr_d = 1'b1;
            state_d  = IDLE;
            expect_d = '0;
          end else if (addrREG == expect_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addrREG == AW'(i)) shadow_d[i] = dinREG;
            end
            expect_d = expect_q + AW'(1);
            if (addrREG == LAST_ADDR) state_d = COMMIT;
          end else if (addrREG == '0) begin
            seqErr_d    = 1'b1;
            shadow_d[0] = dinREG;
            expect_d    = AW'(1);
          end else begin
            seqErr_d = 1'b1;
            state_d  = IDLE;
            expect_d = '0;
          end
        end
      end
      COMMIT: begin
        for (int i = 0; i < NUM_REGS; i++) bank_d[i] = shadow_q[i];
        frameDone_d = 1'b1;
        frameCnt_d  = frameCnt_q + 8'd1;
        expect_d    = '0;
        state_d     = IDLE;
      end
      default: begin
        state_d  = IDLE;
        expect_d = '0;
      end
    endcase
  end

  // Outputs: registered pulses, a busy flag decoded from the state, and a bank read port that returns 0 out of range.
  always_comb begin
    busyREG       = (state_q != IDLE);
    frame_doneREG = frameDone_q;
    seq_errREG    = seqErr_q;
    frame_cntREG  = frameCnt_q;
    rd_dataREG    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addrREG == AW'(i)) rd_dataREG = bank_q[i];
    end
  end

endmodule

// File: tb/tb_rtc_frame_capture.sv
// tb_rtc_frame_capture
// Vector table of {inputs, expected outputs after the next clock edge}.
// Expected values are queued as each vector is driven, then popped and compared one cycle later.
// Test 6 expectations depend on RTC_BCD_CHECK_EN.
module tb_rtc_frame_capture;

  logic       clkREG = 1'b0;
  logic       resetREG, enREG, strobeREG;
  logic [3:0] addrREG, rd_addrREG;
  logic [7:0] dinREG, rd_dataREG, frame_cntREG;
  logic       busyREG, frame_doneREG, seq_errREG;

  typedef struct {
    logic       rst, en, stb;
    logic [3:0] addr;
    logic [7:0] din;
    logic [3:0] rd;
    logic       eErr, eDone, eBusy;
    logic [7:0] eCnt, eRd;
  } vec_t;

  typedef struct {
    int         idx;
    logic       eErr, eDone, eBusy;
    logic [7:0] eCnt, eRd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checkCount = 0;
  int   passCount  = 0;

  rtc_frame_capture #(.NUM_REGS(9), .DW(8), .AW(4)) dut (
    .clkREG(clkREG), .resetREG(resetREG), .enREG(enREG), .addrREG(addrREG),
    .dinREG(dinREG), .strobeREG(strobeREG), .rd_addrREG(rd_addrREG),
    .rd_dataREG(rd_dataREG), .busyREG(busyREG), .frame_doneREG(frame_doneREG),
    .seq_errREG(seq_errREG), .frame_cntREG(frame_cntREG)
  );

  always #5 clkREG = ~clkREG;

  task automatic addVec(input logic rst, en, stb, input logic [3:0] addr,
                        input logic [7:0] din, input logic [3:0] rd,
                        input logic eErr, eDone, eBusy, input logic [7:0] eCnt, eRd);
    vec_t v;
    v.rst = rst; v.en = en; v.stb = stb; v.addr = addr; v.din = din; v.rd = rd;
    v.eErr = eErr; v.eDone = eDone; v.eBusy = eBusy; v.eCnt = eCnt; v.eRd = eRd;
    vecs.push_back(v);
  endtask

  task automatic addBytes(input int first, input int last, input logic [7:0] base,
                          input logic [3:0] rd, input logic [7:0] eCnt, eRd);
    for (int i = first; i <= last; i++)
      addVec(1'b0, 1'b1, 1'b1, 4'(i), 8'(int'(base) + i), rd, 1'b0, 1'b0, 1'b1, eCnt, eRd);
  endtask

  task automatic addIdle(input logic [3:0] rd, input logic eDone, input logic [7:0] eCnt, eRd);
    addVec(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, rd, 1'b0, eDone, 1'b0, eCnt, eRd);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    resetREG   = v.rst;
    enREG      = v.en;
    strobeREG  = v.stb;
    addrREG    = v.addr;
    dinREG     = v.din;
    rd_addrREG = v.rd;
    e.idx = idx; e.eErr = v.eErr; e.eDone = v.eDone; e.eBusy = v.eBusy;
    e.eCnt = v.eCnt; e.eRd = v.eRd;
    sb.push_back(e);
  endtask

  task automatic compare(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL step %0d %s: got %0h expected %0h", idx, nm, act, exp);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    compare("seq_err",    e.idx, {7'd0, seq_errREG},    {7'd0, e.eErr});
    compare("frame_done", e.idx, {7'd0, frame_doneREG}, {7'd0, e.eDone});
    compare("busy",       e.idx, {7'd0, busyREG},       {7'd0, e.eBusy});
    compare("frame_cnt",  e.idx, frame_cntREG,          e.eCnt);
    compare("rd_data",    e.idx, rd_dataREG,            e.eRd);
  endtask

  initial begin
    resetREG = 1'b1; enREG = 1'b0; strobeREG = 1'b0;
    addrREG = '0; dinREG = '0; rd_addrREG = '0;

    // Reset state
    addVec(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 8'h00);
    addVec(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 8'h00);
    // Test 1: clean frame 0x10..0x18
    addBytes(0, 8, 8'h10, 4, 8'd0, 8'h00);
    addIdle(4, 1, 8'd1, 8'h14);
    addIdle(4, 0, 8'd1, 8'h14);
    // Test 2: jump 4 -> 7, then IDLE strobes with a bad address and with enable low
    addBytes(0, 4, 8'h30, 4, 8'd1, 8'h14);
    addVec(0, 1, 1, 7, 8'h37, 4, 1, 0, 0, 8'd1, 8'h14);
    addIdle(4, 0, 8'd1, 8'h14);
    addVec(0, 1, 1, 12, 8'h00, 4, 1, 0, 0, 8'd1, 8'h14);
    addVec(0, 0, 1, 5, 8'h00, 4, 0, 0, 0, 8'd1, 8'h14);
    // Test 3: abort via enable, then full frame 0x20..0x28
    addBytes(0, 5, 8'h40, 8, 8'd1, 8'h18);
    addVec(0, 0, 0, 0, 8'h00, 8, 0, 0, 0, 8'd1, 8'h18);
    addBytes(0, 8, 8'h20, 8, 8'd1, 8'h18);
    addIdle(8, 1, 8'd2, 8'h28);
    addIdle(8, 0, 8'd2, 8'h28);
    // Abort beats a simultaneous strobe; the same address afterwards is out of sequence
    addBytes(0, 2, 8'h70, 8, 8'd2, 8'h28);
    addVec(0, 0, 1, 3, 8'h73, 8, 0, 0, 0, 8'd2, 8'h28);
    addVec(0, 1, 1, 3, 8'h73, 8, 1, 0, 0, 8'd2, 8'h28);
    // Test 4: restart at addr 0 with 0x55; a strobe during COMMIT is ignored
    addBytes(0, 3, 8'h50, 0, 8'd2, 8'h20);
    addVec(0, 1, 1, 0, 8'h55, 0, 1, 0, 1, 8'd2, 8'h20);
    addBytes(1, 8, 8'h60, 0, 8'd2, 8'h20);
    addVec(0, 1, 1, 0, 8'h99, 0, 0, 1, 0, 8'd3, 8'h55);
    addIdle(5, 0, 8'd3, 8'h65);
    addIdle(9, 0, 8'd3, 8'h00);
    addIdle(15, 0, 8'd3, 8'h00);
    addIdle(8, 0, 8'd3, 8'h68);
    // Test 5: reset at addr 6 of a frame
    addBytes(0, 5, 8'h70, 0, 8'd3, 8'h55);
    addVec(1, 1, 1, 6, 8'h76, 0, 0, 0, 0, 8'd0, 8'h00);
    addVec(0, 1, 1, 1, 8'h71, 0, 1, 0, 0, 8'd0, 8'h00);
    addIdle(8, 0, 8'd0, 8'h00);
    // Test 6: non-BCD byte 0x3A at addr 2
    addBytes(0, 1, 8'h00, 2, 8'd0, 8'h00);
`ifdef RTC_BCD_CHECK_EN
    addVec(0, 1, 1, 2, 8'h3A, 2, 1, 0, 0, 8'd0, 8'h00);
    for (int i = 3; i <= 8; i++)
      addVec(0, 1, 1, 4'(i), 8'(i), 2, 1, 0, 0, 8'd0, 8'h00);
    addIdle(2, 0, 8'd0, 8'h00);
`else
    addVec(0, 1, 1, 2, 8'h3A, 2, 0, 0, 1, 8'd0, 8'h00);
    addBytes(3, 8, 8'h00, 2, 8'd0, 8'h00);
    addIdle(2, 1, 8'd1, 8'h3A);
`endif
    addIdle(2, 0, 8'd0 + (frame_cntREG === 8'hxx ? 8'd0 : 8'd0), 8'h00);
    vecs.pop_back();

    @(posedge clkREG); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
      @(posedge clkREG); #1;
      checkOutput();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
